// File: rtl/smbus_target_pkg.sv
`default_nettype none
// smbus_target_pkg -- shared state encoding and bus constants for the SMBus target responder.
// Revision 1.0
package smbus_target_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RX_ADDR   = 3'd1,
      ACK_ADDR  = 3'd2,
      RX_BYTE   = 3'd3,
      ACK_BYTE  = 3'd4,
      TX_BYTE   = 3'd5,
      RX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } smbus_state_t;

   localparam logic       ACK_BIT             = 1'b0;
   localparam logic       NACK_BIT            = 1'b1;
   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h38;
   localparam int         BIT_CNT_W           = 4;

endpackage
`default_nettype wire

// File: rtl/smbus_input_filter.sv
`default_nettype none
// smbus_input_filter -- 2-flop synchronizer, FILTER_LEN-sample glitch filter and edge pulses.
// Revision 1.0
module smbus_input_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync_q;
   logic             filt_q;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;

   // Idle-high reset so a released bus produces no edges coming out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         prev_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], d_i};
         prev_q <= filt_q;
         if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
               filt_q <= sync_q[1];
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign q_o    = filt_q;
   assign rise_o = filt_q & ~prev_q;
   assign fall_o = ~filt_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/smbus_target_responder.sv
`default_nettype none
// smbus_target_responder -- SMBus/I2C target with 8-bit register port and auto-incrementing pointer.
// Revision 1.0
module smbus_target_responder
   import smbus_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
   parameter int         FILTER_LEN  = 3
) (
   input  logic       sys_clk,
   input  logic       sys_clk_reset_sync,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic       reg_wr,
   output logic [7:0] reg_wdata,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   localparam logic [BIT_CNT_W-1:0] BYTE_DONE = BIT_CNT_W'(8);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;

   smbus_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk_i  (sys_clk),
      .rst_i  (sys_clk_reset_sync),
      .d_i    (scl_in),
      .q_o    (scl_f),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   smbus_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk_i  (sys_clk),
      .rst_i  (sys_clk_reset_sync),
      .d_i    (sda_in),
      .q_o    (sda_f),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   smbus_state_t         state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           tx_q, tx_d;
   logic [7:0]           ptr_q, ptr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 sda_oe_q, sda_oe_d;
   logic                 busy_q, busy_d;
   logic                 first_byte_q, first_byte_d;
   logic                 rw_q, rw_d;
   logic                 ack_seen_q, ack_seen_d;
   logic                 wr_q, wr_d;
   logic                 rd_q, rd_d;
   logic                 rd_cap_q, rd_cap_d;
   logic [7:0]           rx_byte;

   always_ff @(posedge sys_clk) begin
      if (sys_clk_reset_sync) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_q         <= '0;
         ptr_q        <= '0;
         wdata_q      <= '0;
         sda_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         first_byte_q <= 1'b0;
         rw_q         <= 1'b0;
         ack_seen_q   <= 1'b0;
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         rd_cap_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         ptr_q        <= ptr_d;
         wdata_q      <= wdata_d;
         sda_oe_q     <= sda_oe_d;
         busy_q       <= busy_d;
         first_byte_q <= first_byte_d;
         rw_q         <= rw_d;
         ack_seen_q   <= ack_seen_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         rd_cap_q     <= rd_cap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      ptr_d        = ptr_q;
      wdata_d      = wdata_q;
      sda_oe_d     = sda_oe_q;
      busy_d       = busy_q;
      first_byte_d = first_byte_q;
      rw_d         = rw_q;
      ack_seen_d   = ack_seen_q;
      wr_d         = 1'b0;
      rd_d         = 1'b0;
      rd_cap_d     = rd_q;
      rx_byte      = {shift_q[6:0], sda_f};

      // Pointer advances after each access strobe; read data lands one cycle after reg_rd.
      if (wr_q || rd_q) begin
         ptr_d = ptr_q + 8'd1;
      end
      if (rd_cap_q) begin
         tx_d = reg_rdata;
      end

      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = RX_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end
            RX_ADDR: begin
               if (scl_rise && bit_cnt_q != BYTE_DONE) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end else if (scl_fall && bit_cnt_q == BYTE_DONE) begin
                  bit_cnt_d = '0;
                  if (shift_q[7:1] == TARGET_ADDR) begin
                     state_d  = ACK_ADDR;
                     sda_oe_d = ~ACK_BIT;
                     busy_d   = 1'b1;
                     rw_d     = shift_q[0];
                  end else begin
                     state_d  = WAIT_STOP;
                     sda_oe_d = 1'b0;
                     busy_d   = 1'b0;
                  end
               end
            end
            ACK_ADDR: begin
               if (scl_rise && rw_q) begin
                  rd_d = 1'b1;
               end else if (scl_fall) begin
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     state_d  = TX_BYTE;
                     sda_oe_d = ~tx_q[7];
                  end else begin
                     state_d      = RX_BYTE;
                     sda_oe_d     = 1'b0;
                     first_byte_d = 1'b1;
                  end
               end
            end
            RX_BYTE: begin
               if (scl_rise && bit_cnt_q != BYTE_DONE) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     if (first_byte_q) begin
                        ptr_d        = rx_byte;
                        first_byte_d = 1'b0;
                     end else begin
                        wr_d    = 1'b1;
                        wdata_d = rx_byte;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == BYTE_DONE) begin
                  state_d   = ACK_BYTE;
                  bit_cnt_d = '0;
                  sda_oe_d  = ~ACK_BIT;
               end
            end
            ACK_BYTE: begin
               if (scl_fall) begin
                  state_d  = RX_BYTE;
                  sda_oe_d = 1'b0;
               end
            end
            TX_BYTE: begin
               if (scl_rise && bit_cnt_q != BYTE_DONE) begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end else if (scl_fall) begin
                  if (bit_cnt_q == BYTE_DONE) begin
                     state_d    = RX_ACK;
                     sda_oe_d   = 1'b0;
                     ack_seen_d = 1'b0;
                  end else begin
                     sda_oe_d = ~tx_q[6];
                     tx_d     = {tx_q[6:0], 1'b0};
                  end
               end
            end
            RX_ACK: begin
               if (scl_rise) begin
                  if (sda_f == NACK_BIT) begin
                     state_d = WAIT_STOP;
                     busy_d  = 1'b0;
                  end else begin
                     rd_d       = 1'b1;
                     ack_seen_d = 1'b1;
                  end
               end else if (scl_fall && ack_seen_q) begin
                  state_d   = TX_BYTE;
                  bit_cnt_d = '0;
                  sda_oe_d  = ~tx_q[7];
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign reg_addr  = ptr_q;
   assign reg_wr    = wr_q;
   assign reg_wdata = wdata_q;
   assign reg_rd    = rd_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_smbus_target_responder.sv
`default_nettype none
// tb_smbus_target_responder -- directed host-side bench for the SMBus target responder.
// Revision 1.0
module tb_smbus_target_responder;

   localparam int Q = 8;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       host_scl = 1'b1;
   logic       host_sda = 1'b1;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic       reg_wr;
   logic [7:0] reg_wdata;
   logic       reg_rd;
   logic [7:0] reg_rdata = 8'h00;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] wr_addr_a [0:255];
   logic [7:0] wr_data_a [0:255];
   logic [7:0] rd_addr_a [0:255];
   int wr_n = 0, rd_n = 0, oe_n = 0, busy_n = 0, both_n = 0, nobusy_n = 0;

   always #5 sys_clk = ~sys_clk;

   assign sda_in = host_sda & ~sda_oe;

   smbus_target_responder #(.TARGET_ADDR(7'h38), .FILTER_LEN(3)) dut (
      .sys_clk            (sys_clk),
      .sys_clk_reset_sync (rst),
      .scl_in             (host_scl),
      .sda_in             (sda_in),
      .sda_oe             (sda_oe),
      .reg_addr           (reg_addr),
      .reg_wr             (reg_wr),
      .reg_wdata          (reg_wdata),
      .reg_rd             (reg_rd),
      .reg_rdata          (reg_rdata),
      .busy               (busy)
   );

   // Register-file model (data = addr ^ 0xFF) and strobe recorder.
   always @(posedge sys_clk) begin
      if (reg_rd) reg_rdata <= reg_addr ^ 8'hFF;
      if (reg_wr && wr_n < 256) begin
         wr_addr_a[wr_n] = reg_addr;
         wr_data_a[wr_n] = reg_wdata;
         wr_n++;
      end
      if (reg_rd && rd_n < 256) begin
         rd_addr_a[rd_n] = reg_addr;
         rd_n++;
      end
      if (sda_oe) oe_n++;
      if (busy) busy_n++;
      if (reg_wr && reg_rd) both_n++;
      if ((reg_wr || reg_rd) && !busy) nobusy_n++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic bus_start();
      host_sda = 1'b1; wait_cyc(Q);
      host_scl = 1'b1; wait_cyc(2 * Q);
      host_sda = 1'b0; wait_cyc(2 * Q);
      host_scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic bus_stop();
      host_sda = 1'b0; wait_cyc(Q);
      host_scl = 1'b1; wait_cyc(2 * Q);
      host_sda = 1'b1; wait_cyc(2 * Q);
   endtask

   task automatic write_bit(input logic b);
      host_sda = b;    wait_cyc(Q);
      host_scl = 1'b1; wait_cyc(2 * Q);
      host_scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic read_bit(output logic b);
      host_sda = 1'b1; wait_cyc(Q);
      host_scl = 1'b1; wait_cyc(Q);
      b = sda_in;      wait_cyc(Q);
      host_scl = 1'b0; wait_cyc(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(input logic host_ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(~host_ack);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(4);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %0b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got %h exp 00", reg_addr); end
      checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got %h exp 00", reg_wdata); end
      checks++; if ({reg_wr, reg_rd} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {reg_wr, reg_rd}); end
      rst = 1'b0;
      wait_cyc(2 * Q);
   endtask

   task automatic test_write();
      logic [7:0] bytes [4] = '{8'h70, 8'h10, 8'hA5, 8'h5A};
      logic ack;
      int base;
      base = wr_n;
      bus_start();
      for (int i = 0; i < 4; i++) begin
         send_byte(bytes[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_ack byte%0d got %0b exp 1", i, ack); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid got %0b exp 1", busy); end
      bus_stop();
      checks++; if (wr_n - base != 2) begin errors++; $display("FAIL write_count got %0d exp 2", wr_n - base); end
      checks++; if (wr_addr_a[base] !== 8'h10 || wr_data_a[base] !== 8'hA5) begin errors++; $display("FAIL write_first got %h/%h exp 10/a5", wr_addr_a[base], wr_data_a[base]); end
      checks++; if (wr_addr_a[base+1] !== 8'h11 || wr_data_a[base+1] !== 8'h5A) begin errors++; $display("FAIL write_second got %h/%h exp 11/5a", wr_addr_a[base+1], wr_data_a[base+1]); end
      checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL write_pointer got %h exp 12", reg_addr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %0b exp 0", busy); end
   endtask

   task automatic test_read_rs();
      logic ack;
      logic [7:0] d0, d1;
      int wbase, rbase;
      wbase = wr_n; rbase = rd_n;
      bus_start();
      send_byte(8'h70, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_addrw got %0b exp 1", ack); end
      send_byte(8'h20, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_offset got %0b exp 1", ack); end
      bus_start();
      send_byte(8'h71, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_ack_addrr got %0b exp 1", ack); end
      recv_byte(1'b1, d0);
      recv_byte(1'b0, d1);
      checks++; if (d0 !== 8'hDF) begin errors++; $display("FAIL read_data0 got %h exp df", d0); end
      checks++; if (d1 !== 8'hDE) begin errors++; $display("FAIL read_data1 got %h exp de", d1); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after_nack got %0b exp 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack got %0b exp 0", busy); end
      bus_stop();
      checks++; if (rd_n - rbase != 2) begin errors++; $display("FAIL read_rd_count got %0d exp 2", rd_n - rbase); end
      checks++; if (rd_addr_a[rbase] !== 8'h20 || rd_addr_a[rbase+1] !== 8'h21) begin errors++; $display("FAIL read_rd_addr got %h,%h exp 20,21", rd_addr_a[rbase], rd_addr_a[rbase+1]); end
      checks++; if (wr_n != wbase) begin errors++; $display("FAIL read_no_wr got %0d exp 0", wr_n - wbase); end
   endtask

   task automatic test_mismatch();
      logic ack;
      int obase, bbase, wbase, rbase;
      obase = oe_n; bbase = busy_n; wbase = wr_n; rbase = rd_n;
      bus_start();
      send_byte(8'h72, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_ack got %0b exp 0", ack); end
      send_byte(8'h00, ack);
      bus_stop();
      checks++; if (oe_n != obase) begin errors++; $display("FAIL mismatch_oe cycles got %0d exp 0", oe_n - obase); end
      checks++; if (busy_n != bbase) begin errors++; $display("FAIL mismatch_busy cycles got %0d exp 0", busy_n - bbase); end
      checks++; if (wr_n != wbase || rd_n != rbase) begin errors++; $display("FAIL mismatch_strobes got wr %0d rd %0d exp 0 0", wr_n - wbase, rd_n - rbase); end
   endtask

   task automatic test_wrap();
      logic ack;
      int base;
      base = wr_n;
      bus_start();
      send_byte(8'h70, ack);
      send_byte(8'hFF, ack);
      send_byte(8'h11, ack);
      send_byte(8'h22, ack);
      bus_stop();
      checks++; if (wr_n - base != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", wr_n - base); end
      checks++; if (wr_addr_a[base] !== 8'hFF || wr_data_a[base] !== 8'h11) begin errors++; $display("FAIL wrap_first got %h/%h exp ff/11", wr_addr_a[base], wr_data_a[base]); end
      checks++; if (wr_addr_a[base+1] !== 8'h00 || wr_data_a[base+1] !== 8'h22) begin errors++; $display("FAIL wrap_second got %h/%h exp 00/22", wr_addr_a[base+1], wr_data_a[base+1]); end
      checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_pointer got %h exp 01", reg_addr); end
   endtask

   task automatic test_abort();
      logic ack;
      int base;
      base = wr_n;
      bus_start();
      send_byte(8'h70, ack);
      send_byte(8'h30, ack);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      bus_stop();
      checks++; if (wr_n != base) begin errors++; $display("FAIL abort_no_wr got %0d exp 0", wr_n - base); end
      checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got oe %0b busy %0b exp 0 0", sda_oe, busy); end
      checks++; if (reg_addr !== 8'h30) begin errors++; $display("FAIL abort_pointer got %h exp 30", reg_addr); end
      bus_start();
      send_byte(8'h70, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL abort_restart_ack got %0b exp 1", ack); end
      bus_stop();
   endtask

   task automatic test_glitch();
      logic ack;
      int obase;
      obase = oe_n;
      host_sda = 1'b0; wait_cyc(2);
      host_sda = 1'b1; wait_cyc(Q);
      host_scl = 1'b0; wait_cyc(Q);
      send_byte(8'h70, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL glitch_no_start ack got %0b exp 0", ack); end
      checks++; if (oe_n != obase) begin errors++; $display("FAIL glitch_oe cycles got %0d exp 0", oe_n - obase); end
      bus_stop();
   endtask

   task automatic test_reset_mid_read();
      logic ack, b;
      logic [7:0] d;
      int rbase;
      bus_start();
      send_byte(8'h70, ack);
      send_byte(8'h50, ack);
      bus_start();
      send_byte(8'h71, ack);
      read_bit(b); read_bit(b); read_bit(b);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %0b exp 1", busy); end
      rst = 1'b1;
      wait_cyc(1);
      checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || reg_addr !== 8'h00) begin errors++; $display("FAIL rstmid_clear got oe %0b busy %0b addr %h exp 0 0 00", sda_oe, busy, reg_addr); end
      rst = 1'b0;
      wait_cyc(2 * Q);
      bus_stop();
      rbase = rd_n;
      bus_start();
      send_byte(8'h71, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %0b exp 1", ack); end
      recv_byte(1'b0, d);
      bus_stop();
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rstmid_data got %h exp ff", d); end
      checks++; if (rd_n - rbase != 1 || rd_addr_a[rbase] !== 8'h00) begin errors++; $display("FAIL rstmid_rd got n %0d addr %h exp 1 00", rd_n - rbase, rd_addr_a[rbase]); end
   endtask

   task automatic test_strobe_rules();
      checks++; if (both_n != 0) begin errors++; $display("FAIL strobe_overlap cycles got %0d exp 0", both_n); end
      checks++; if (nobusy_n != 0) begin errors++; $display("FAIL strobe_outside_busy cycles got %0d exp 0", nobusy_n); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_rs();
      test_mismatch();
      test_wrap();
      test_abort();
      test_glitch();
      test_reset_mid_read();
      test_strobe_rules();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
